// File: rtl/button_seq_player_pkg.sv
// Shared definitions for the attract-mode button sequencer: button codes,
// default field widths and the playback state encoding.
package button_seq_player_pkg;

  localparam int BTN_W_DEF = 5;
  localparam int SEQ_DLY_W = 8;

  function automatic int seq_entry_w(input int btn_w, input int dly_w);
    return btn_w + dly_w;
  endfunction

  localparam int SEQ_ENTRY_W = seq_entry_w(BTN_W_DEF, SEQ_DLY_W);

  typedef enum logic [BTN_W_DEF-1:0] {
    BUTTON_NONE  = 5'd0,
    BUTTON_UP    = 5'd1,
    BUTTON_DOWN  = 5'd2,
    BUTTON_LEFT  = 5'd3,
    BUTTON_RIGHT = 5'd4,
    BUTTON_MID   = 5'd5
  } button_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GAP   = 2'd1,
    ST_PULSE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/seq_prog_ram.sv
// Program store for the sequencer: synchronous write, registered read.
// A write to the address being read is forwarded so a freshly written entry 0 is seen at start.
module seq_prog_ram
  import button_seq_player_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = SEQ_ENTRY_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      r_mem[wr_addr_i] <= wr_data_i;
    end
    if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
      r_rd_data <= wr_data_i;
    end else begin
      r_rd_data <= r_mem[rd_addr_i];
    end
  end

  assign rd_data_o = r_rd_data;

endmodule

// File: rtl/button_seq_player.sv
// Replays {code, pre-delay} entries onto the game button bus; passes live buttons when idle.
//   state    | meaning
//   ST_IDLE  | live passthrough, program writable, waiting for start
//   ST_GAP   | driving NONE for the current entry's pre-delay
//   ST_PULSE | driving the current entry's code for PULSE_LEN cycles
module button_seq_player
  import button_seq_player_pkg::*;
#(
  parameter int BTN_W     = BTN_W_DEF,
  parameter int DEPTH     = 16,
  parameter int DLY_W     = SEQ_DLY_W,
  parameter int PULSE_LEN = 1,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic                   loop_i,
  input  logic [AW:0]            prog_len_i,
  input  logic                   wr_en_i,
  input  logic [AW-1:0]          wr_addr_i,
  input  logic [BTN_W+DLY_W-1:0] wr_data_i,
  input  logic [BTN_W-1:0]       live_button_i,
  output logic [BTN_W-1:0]       button_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [AW-1:0]          step_o
);

  localparam int EW = BTN_W + DLY_W;
  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam logic [PW-1:0]    PLS_LAST = PW'(PULSE_LEN - 1);
  localparam logic [BTN_W-1:0] NONE     = BTN_W'(BUTTON_NONE);

  seq_state_e       r_state, w_state_nxt;
  logic [AW:0]      r_len, w_len_nxt;
  logic [AW-1:0]    r_step, w_step_nxt, w_enter_idx, w_rd_addr;
  logic [DLY_W-1:0] r_dly, w_dly_nxt;
  logic [PW-1:0]    r_pls, w_pls_nxt;
  logic [BTN_W-1:0] r_code, w_code_nxt, r_btn, w_btn_nxt;
  logic             r_done, w_done_nxt;
  logic             w_enter, w_last, w_wr_en;
  logic [AW:0]      w_step_inc;
  logic [EW-1:0]    w_rd_data;
  logic [BTN_W-1:0] w_ent_code;
  logic [DLY_W-1:0] w_ent_dly;

  assign w_ent_code = w_rd_data[EW-1 -: BTN_W];
  assign w_ent_dly  = w_rd_data[DLY_W-1:0];
  assign w_last     = (({1'b0, r_step} + 1'b1) == r_len);
  assign w_wr_en    = wr_en_i && (r_state == ST_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_step_nxt  = r_step;
    w_dly_nxt   = r_dly;
    w_pls_nxt   = r_pls;
    w_code_nxt  = r_code;
    w_btn_nxt   = r_btn;
    w_done_nxt  = 1'b0;
    w_enter     = 1'b0;
    w_enter_idx = '0;

    case (r_state)
      ST_IDLE: begin
        w_btn_nxt  = live_button_i;
        w_step_nxt = '0;
        if (start_i) begin
          w_len_nxt = prog_len_i;
          if (prog_len_i == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_enter = 1'b1;
          end
        end
      end
      ST_GAP: begin
        w_btn_nxt = NONE;
        if (r_dly == '0) begin
          w_state_nxt = ST_PULSE;
          w_btn_nxt   = r_code;
          w_pls_nxt   = PLS_LAST;
        end else begin
          w_dly_nxt = r_dly - 1'b1;
        end
      end
      ST_PULSE: begin
        if (r_pls != '0) begin
          w_pls_nxt = r_pls - 1'b1;
        end else if (!w_last) begin
          w_enter     = 1'b1;
          w_enter_idx = r_step + 1'b1;
        end else if (loop_i) begin
          w_enter = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_btn_nxt   = NONE;
          w_step_nxt  = '0;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_btn_nxt   = NONE;
      end
    endcase

    // Entry data is already waiting in the RAM output thanks to the prefetch below.
    if (w_enter) begin
      w_step_nxt = w_enter_idx;
      w_code_nxt = w_ent_code;
      if (w_ent_dly == '0) begin
        w_state_nxt = ST_PULSE;
        w_btn_nxt   = w_ent_code;
        w_pls_nxt   = PLS_LAST;
      end else begin
        w_state_nxt = ST_GAP;
        w_btn_nxt   = NONE;
        w_dly_nxt   = w_ent_dly - 1'b1;
      end
    end

    if (abort_i) begin
      w_state_nxt = ST_IDLE;
      w_btn_nxt   = NONE;
      w_step_nxt  = '0;
      w_done_nxt  = 1'b0;
    end
  end

  // Read the entry after the one being run, so it is ready when the current pulse ends.
  assign w_step_inc = {1'b0, w_step_nxt} + 1'b1;
  assign w_rd_addr  = ((w_state_nxt == ST_IDLE) || (w_step_inc >= w_len_nxt)) ? '0
                                                                               : w_step_inc[AW-1:0];

  seq_prog_ram #(
    .DEPTH (DEPTH),
    .W     (EW),
    .AW    (AW)
  ) u_prog_ram (
    .clk       (clk),
    .wr_en_i   (w_wr_en),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rd_addr_i (w_rd_addr),
    .rd_data_o (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_step  <= '0;
      r_dly   <= '0;
      r_pls   <= '0;
      r_code  <= NONE;
      r_btn   <= NONE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_step  <= w_step_nxt;
      r_dly   <= w_dly_nxt;
      r_pls   <= w_pls_nxt;
      r_code  <= w_code_nxt;
      r_btn   <= w_btn_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign button_o = r_btn;
  assign busy_o   = (r_state != ST_IDLE);
  assign done_o   = r_done;
  assign step_o   = r_step;

endmodule
